stamp_ctrl: RTL and testbench
=============================

// Module: stamp_ctrl
// PURPOSE
//  Controller/owner of the free-running timestamp counter in osnt_timestamp. Adds a programmable
//  fixed-point step each cycle (drift trim), applies software loads immediately or aligned to the
//  next PPS edge, and times out an unanswered PPS arm. Feeds stamp_counter to the rx/tx stampers.
// PARAMETERS
//  TIMESTAMP_WIDTH  64          integer part of timestamp, bits
//  FRAC_WIDTH       32          fractional accumulator bits
//  STEP_WIDTH       40          step width: 8 integer + FRAC_WIDTH fraction bits
//  DEFAULT_STEP     40'h01_0000_0000  step at reset (1.0 per cycle)
//  PPS_TIMEOUT      32'd200_000_000   cycles an armed load waits for PPS
// PORTS
//  axi_aclk          in   1    single clock
//  axi_reset         in   1    asynchronous, active-high reset
//  cfg_step          in   STEP_WIDTH  new step value
//  cfg_step_wr       in   1    1-cycle strobe: latch cfg_step
//  cfg_load_val      in   TIMESTAMP_WIDTH  value to load
//  cfg_load_wr       in   1    1-cycle strobe: request load
//  cfg_load_on_pps   in   1    sampled with cfg_load_wr: 0=immediate, 1=on next PPS
//  pps_in            in   1    asynchronous pulse-per-second
//  stamp_counter     out  TIMESTAMP_WIDTH  current timestamp (integer part)
//  load_armed        out  1    1 while waiting for PPS
//  pps_timeout       out  1    sticky: armed load expired; cleared by next cfg_load_wr
//  pps_stamp         out  TIMESTAMP_WIDTH  stamp_counter captured at PPS edge (optional)
//  pps_stamp_valid   out  1    1-cycle strobe with pps_stamp (optional)
// BEHAVIOUR
//  Reset: stamp_counter=0, frac=0, step=DEFAULT_STEP, state IDLE, load_armed=0, pps_timeout=0,
//   pps_stamp=0, pps_stamp_valid=0. Reset mid-ARMED discards the pending load.
//  Accumulator {stamp_counter,frac} += zero-extended step every cycle, modulo 2^(TW+FW) (wraps silently).
//  cfg_step_wr: step register updated at that edge; new step first added the following cycle.
//  pps_in: 2-flop synchronizer + rising-edge detect; pps_edge asserted 3 cycles after pps_in rises.
//  FSM IDLE: cfg_load_wr & !cfg_load_on_pps -> at that edge stamp_counter<=cfg_load_val, frac<=0
//   (no step added that cycle), stay IDLE. cfg_load_wr & cfg_load_on_pps -> latch value, clear
//   timeout cnt and pps_timeout, go ARMED.
//  ARMED: load_armed=1; timeout cnt +1/cycle. pps_edge -> stamp_counter<=latched val, frac<=0, IDLE.
//   cnt==PPS_TIMEOUT-1 with no edge -> pps_timeout<=1, IDLE, value dropped.
//   New cfg_load_wr in ARMED: replaces latched value/mode, restarts cnt (immediate mode loads now, IDLE).
//  Simultaneous: pps_edge and timeout same cycle -> load wins, no timeout. cfg_load_wr and pps_edge
//   same cycle in ARMED -> new request wins, old value dropped. cfg_step_wr with load -> both applied.
// CONFIGURATION
//  STAMP_CTRL_PPS_CAPTURE_EN defined: on every pps_edge (any state) pps_stamp<=stamp_counter value
//   before any load that cycle, pps_stamp_valid=1 for one cycle.
//  Not defined: pps_stamp tied 0, pps_stamp_valid tied 0, no capture register.
// STRUCTURE
//  stamp_ctrl_pkg: state enum (ST_IDLE, ST_ARMED), default width/step localparams.
//  Sub-module pps_sync: synchronizer + rising-edge detect, output pps_edge.
// TESTING
//  Reset, step default, 10 cycles -> stamp_counter=10, pps_stamp_valid never set.
//  cfg_step=40'h00_8000_0000 written, 8 cycles -> counter advances by 4; step 40'h02_0000_0000 -> +2/cycle.
//  Immediate load 64'hFFFF_FFFF_FFFF_FFFE, step 1.0 -> FFFE, FFFF, 0 (wrap), 1 on successive cycles.
//  Armed load 64'd1000, pps_in pulse 50 cycles later -> load_armed 1 until edge, counter=1000 at
//   edge cycle then 1001; with EN, pps_stamp=pre-load value, valid 1 cycle.
//  Armed, PPS_TIMEOUT=16, no PPS -> after 16 cycles pps_timeout=1, load_armed=0, counter unaffected.
//  Assert axi_reset while ARMED, then PPS -> no load, counter restarts from 0.

Source files
------------

// File: rtl/stamp_ctrl_pkg.sv
// rtl/stamp_ctrl_pkg.sv - shared state encoding and default widths for the timestamp controller
package stamp_ctrl_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ARMED = 1'b1
   } state_t;

   localparam int          TIMESTAMP_WIDTH_DEF = 64;
   localparam int          FRAC_WIDTH_DEF      = 32;
   localparam int          STEP_WIDTH_DEF      = 40;
   localparam logic [39:0] DEFAULT_STEP_DEF    = 40'h01_0000_0000;
   localparam logic [31:0] PPS_TIMEOUT_DEF     = 32'd200_000_000;

endpackage

// File: rtl/stamp_ctrl_pps_sync.sv
// rtl/stamp_ctrl_pps_sync.sv - pps_in synchronizer with registered rising-edge pulse
module pps_sync (
   input  logic clk,
   input  logic rst,
   input  logic pps_in,
   output logic pps_edge
);

   logic sync_1;
   logic sync_2;
   logic sync_prev;

   // Edge pulse is registered, so it appears three cycles after pps_in rises
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_1    <= 1'b0;
         sync_2    <= 1'b0;
         sync_prev <= 1'b0;
         pps_edge  <= 1'b0;
      end else begin
         sync_1    <= pps_in;
         sync_2    <= sync_1;
         sync_prev <= sync_2;
         pps_edge  <= sync_2 & ~sync_prev;
      end
   end

endmodule

// File: rtl/stamp_ctrl.sv
// rtl/stamp_ctrl.sv - fractional-step timestamp counter with immediate or PPS-aligned loads
// Optional PPS capture of the counter is enabled by defining STAMP_CTRL_PPS_CAPTURE_EN.
module stamp_ctrl
   import stamp_ctrl_pkg::*;
#(
   parameter int                   TIMESTAMP_WIDTH = TIMESTAMP_WIDTH_DEF,
   parameter int                   FRAC_WIDTH      = FRAC_WIDTH_DEF,
   parameter int                   STEP_WIDTH      = STEP_WIDTH_DEF,
   parameter logic [STEP_WIDTH-1:0] DEFAULT_STEP   = DEFAULT_STEP_DEF,
   parameter logic [31:0]          PPS_TIMEOUT     = PPS_TIMEOUT_DEF
) (
   input  logic                       axi_aclk,
   input  logic                       axi_reset,
   input  logic [STEP_WIDTH-1:0]      cfg_step,
   input  logic                       cfg_step_wr,
   input  logic [TIMESTAMP_WIDTH-1:0] cfg_load_val,
   input  logic                       cfg_load_wr,
   input  logic                       cfg_load_on_pps,
   input  logic                       pps_in,
   output logic [TIMESTAMP_WIDTH-1:0] stamp_counter,
   output logic                       load_armed,
   output logic                       pps_timeout,
   output logic [TIMESTAMP_WIDTH-1:0] pps_stamp,
   output logic                       pps_stamp_valid
);

   localparam int ACC_WIDTH = TIMESTAMP_WIDTH + FRAC_WIDTH;

   state_t                     state;
   logic [FRAC_WIDTH-1:0]      frac;
   logic [STEP_WIDTH-1:0]      step;
   logic [TIMESTAMP_WIDTH-1:0] pending_val;
   logic [31:0]                wait_cnt;
   logic [ACC_WIDTH-1:0]       acc_next;
   logic                       pps_edge;

   pps_sync u_pps_sync (
      .clk      (axi_aclk),
      .rst      (axi_reset),
      .pps_in   (pps_in),
      .pps_edge (pps_edge)
   );

   assign acc_next = {stamp_counter, frac} + {{(ACC_WIDTH - STEP_WIDTH){1'b0}}, step};

   always_ff @(posedge axi_aclk or posedge axi_reset) begin
      if (axi_reset) begin
         state         <= ST_IDLE;
         stamp_counter <= '0;
         frac          <= '0;
         step          <= DEFAULT_STEP;
         pending_val   <= '0;
         wait_cnt      <= '0;
         load_armed    <= 1'b0;
         pps_timeout   <= 1'b0;
      end else begin
         if (cfg_step_wr)
            step <= cfg_step;

         {stamp_counter, frac} <= acc_next;

         // A fresh request always wins over a PPS edge or timeout in the same cycle
         if (cfg_load_wr) begin
            pps_timeout <= 1'b0;
            if (cfg_load_on_pps) begin
               pending_val <= cfg_load_val;
               wait_cnt    <= '0;
               state       <= ST_ARMED;
               load_armed  <= 1'b1;
            end else begin
               stamp_counter <= cfg_load_val;
               frac          <= '0;
               state         <= ST_IDLE;
               load_armed    <= 1'b0;
            end
         end else begin
            case (state)
               ST_IDLE: begin
                  load_armed <= 1'b0;
               end
               ST_ARMED: begin
                  wait_cnt <= wait_cnt + 32'd1;
                  if (pps_edge) begin
                     stamp_counter <= pending_val;
                     frac          <= '0;
                     state         <= ST_IDLE;
                     load_armed    <= 1'b0;
                  end else if (wait_cnt == PPS_TIMEOUT - 32'd1) begin
                     pps_timeout <= 1'b1;
                     state       <= ST_IDLE;
                     load_armed  <= 1'b0;
                  end
               end
               default: begin
                  state      <= ST_IDLE;
                  load_armed <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef STAMP_CTRL_PPS_CAPTURE_EN
   // Captures the counter as it stood before any load applied on the same edge
   always_ff @(posedge axi_aclk or posedge axi_reset) begin
      if (axi_reset) begin
         pps_stamp       <= '0;
         pps_stamp_valid <= 1'b0;
      end else begin
         pps_stamp_valid <= pps_edge;
         if (pps_edge)
            pps_stamp <= stamp_counter;
      end
   end
`else
   assign pps_stamp       = '0;
   assign pps_stamp_valid = 1'b0;
`endif

endmodule

// File: tb/tb_stamp_ctrl.sv
// tb/tb_stamp_ctrl.sv - scoreboard bench for stamp_ctrl (honours STAMP_CTRL_PPS_CAPTURE_EN)
module tb_stamp_ctrl;

   logic        axi_aclk = 1'b0;
   logic        axi_reset;
   logic [39:0] cfg_step;
   logic        cfg_step_wr;
   logic [63:0] cfg_load_val;
   logic        cfg_load_wr;
   logic        cfg_load_on_pps;
   logic        pps_in;
   logic [63:0] stamp_counter;
   logic        load_armed;
   logic        pps_timeout;
   logic [63:0] pps_stamp;
   logic        pps_stamp_valid;

   int          checks = 0;
   int          errors = 0;
   int          valid_cnt = 0;
   logic [63:0] exp_q[$];

   always #5 axi_aclk = ~axi_aclk;

   stamp_ctrl #(
      .PPS_TIMEOUT (32'd16)
   ) dut (
      .axi_aclk        (axi_aclk),
      .axi_reset       (axi_reset),
      .cfg_step        (cfg_step),
      .cfg_step_wr     (cfg_step_wr),
      .cfg_load_val    (cfg_load_val),
      .cfg_load_wr     (cfg_load_wr),
      .cfg_load_on_pps (cfg_load_on_pps),
      .pps_in          (pps_in),
      .stamp_counter   (stamp_counter),
      .load_armed      (load_armed),
      .pps_timeout     (pps_timeout),
      .pps_stamp       (pps_stamp),
      .pps_stamp_valid (pps_stamp_valid)
   );

   always @(negedge axi_aclk)
      if (pps_stamp_valid === 1'b1)
         valid_cnt++;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Queue the expected counter for the next edge, then compare once the edge has passed
   task automatic tick(input string tag, input logic [63:0] exp);
      exp_q.push_back(exp);
      @(posedge axi_aclk);
      @(negedge axi_aclk);
      check(tag, stamp_counter, exp_q.pop_front());
   endtask

   initial begin
      axi_reset       = 1'b1;
      cfg_step        = '0;
      cfg_step_wr     = 1'b0;
      cfg_load_val    = '0;
      cfg_load_wr     = 1'b0;
      cfg_load_on_pps = 1'b0;
      pps_in          = 1'b0;
      repeat (3) @(negedge axi_aclk);
      check("rst_counter", stamp_counter, 64'd0);
      check("rst_armed", {63'd0, load_armed}, 64'd0);
      check("rst_timeout", {63'd0, pps_timeout}, 64'd0);
      check("rst_pps_stamp", pps_stamp, 64'd0);
      check("rst_pps_valid", {63'd0, pps_stamp_valid}, 64'd0);
      axi_reset = 1'b0;

      for (int i = 1; i <= 10; i++) tick("count_default", 64'(i));

      cfg_step    = 40'h00_8000_0000;
      cfg_step_wr = 1'b1;
      tick("step_old_used", 64'd11);
      cfg_step_wr = 1'b0;
      for (int k = 1; k <= 8; k++) tick("step_half", 64'(11 + k / 2));

      cfg_step    = 40'h02_0000_0000;
      cfg_step_wr = 1'b1;
      tick("step_two_first", 64'd15);
      cfg_step_wr = 1'b0;
      for (int k = 1; k <= 3; k++) tick("step_two", 64'(15 + 2 * k));

      cfg_step        = 40'h01_0000_0000;
      cfg_step_wr     = 1'b1;
      cfg_load_val    = 64'hFFFF_FFFF_FFFF_FFFE;
      cfg_load_wr     = 1'b1;
      cfg_load_on_pps = 1'b0;
      tick("load_imm", 64'hFFFF_FFFF_FFFF_FFFE);
      cfg_step_wr = 1'b0;
      cfg_load_wr = 1'b0;
      tick("wrap_ffff", 64'hFFFF_FFFF_FFFF_FFFF);
      tick("wrap_zero", 64'd0);
      tick("wrap_one", 64'd1);

      cfg_load_val    = 64'd1000;
      cfg_load_wr     = 1'b1;
      cfg_load_on_pps = 1'b1;
      tick("arm", 64'd2);
      cfg_load_wr = 1'b0;
      check("armed_set", {63'd0, load_armed}, 64'd1);
      for (int k = 3; k <= 12; k++) tick("armed_run", 64'(k));
      cfg_load_wr = 1'b1;
      tick("rearm", 64'd13);
      cfg_load_wr = 1'b0;
      for (int k = 14; k <= 23; k++) tick("rearm_run", 64'(k));
      check("rearm_still_armed", {63'd0, load_armed}, 64'd1);
      check("rearm_no_timeout", {63'd0, pps_timeout}, 64'd0);
      pps_in = 1'b1;
      for (int k = 24; k <= 26; k++) begin
         tick("pps_sync_delay", 64'(k));
         check("pps_wait_armed", {63'd0, load_armed}, 64'd1);
      end
      tick("pps_load", 64'd1000);
      check("pps_load_disarm", {63'd0, load_armed}, 64'd0);
`ifdef STAMP_CTRL_PPS_CAPTURE_EN
      check("pps_stamp_val", pps_stamp, 64'd26);
      check("pps_stamp_strobe", {63'd0, pps_stamp_valid}, 64'd1);
`else
      check("pps_stamp_tied", pps_stamp, 64'd0);
      check("pps_valid_tied", {63'd0, pps_stamp_valid}, 64'd0);
`endif
      pps_in = 1'b0;
      tick("after_load", 64'd1001);
      check("pps_valid_one_cycle", {63'd0, pps_stamp_valid}, 64'd0);
      tick("after_load2", 64'd1002);

      cfg_load_val    = 64'd5555;
      cfg_load_wr     = 1'b1;
      cfg_load_on_pps = 1'b1;
      tick("arm_to", 64'd1003);
      cfg_load_wr = 1'b0;
      for (int k = 1; k <= 15; k++) tick("to_wait", 64'(1003 + k));
      check("to_armed_before", {63'd0, load_armed}, 64'd1);
      check("to_flag_before", {63'd0, pps_timeout}, 64'd0);
      tick("to_expire", 64'd1019);
      check("to_disarm", {63'd0, load_armed}, 64'd0);
      check("to_flag", {63'd0, pps_timeout}, 64'd1);
      pps_in = 1'b1;
      for (int k = 1020; k <= 1023; k++) tick("to_pps_ignored", 64'(k));
      pps_in = 1'b0;
      tick("to_pps_ignored", 64'd1024);
      check("to_flag_sticky", {63'd0, pps_timeout}, 64'd1);

      cfg_load_val    = 64'd77;
      cfg_load_wr     = 1'b1;
      cfg_load_on_pps = 1'b0;
      tick("load_clears_to", 64'd77);
      cfg_load_wr = 1'b0;
      check("to_cleared", {63'd0, pps_timeout}, 64'd0);

      cfg_load_val    = 64'd1000;
      cfg_load_wr     = 1'b1;
      cfg_load_on_pps = 1'b1;
      tick("arm_rst", 64'd78);
      cfg_load_wr = 1'b0;
      check("arm_rst_armed", {63'd0, load_armed}, 64'd1);
      axi_reset = 1'b1;
      repeat (2) @(negedge axi_aclk);
      check("mid_rst_counter", stamp_counter, 64'd0);
      check("mid_rst_armed", {63'd0, load_armed}, 64'd0);
      axi_reset = 1'b0;
      pps_in    = 1'b1;
      for (int k = 1; k <= 5; k++) tick("rst_pps_no_load", 64'(k));
      pps_in = 1'b0;
      tick("rst_pps_no_load", 64'd6);
      check("rst_pps_disarmed", {63'd0, load_armed}, 64'd0);

`ifdef STAMP_CTRL_PPS_CAPTURE_EN
      check("valid_pulse_count", 64'(valid_cnt), 64'd3);
`else
      check("valid_never_set", 64'(valid_cnt), 64'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
